// File: rtl/stage_db_pkg.sv
// Shared definitions for the stage-database stream: word width, FSM states
// and the slot-offset helper used when packing words into wide records.
package stage_db_pkg;

  localparam int unsigned DATA_WIDTH_12 = 12;
  localparam int unsigned DEFAULT_VALUE = 1010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    COLLECT = 3'd2,
    THRESH  = 3'd3,
    DONE    = 3'd4
  } stage_state_e;

  // Bit offset of word slot k in a record packed with word 0 at the LSBs.
  function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/stage_param_shadow.sv
// Shadow record with indexed word writes plus the parallel-load output
// register that presents completed records to the consumer.
// Handshake: the record on params_o transfers on a rising edge where valid_o
// and ready_i are both high; valid_o never drops without such a transfer.
// A completed record loads only into an empty or draining output register;
// otherwise it is dropped and overflow_o is latched until clear_i.
module stage_param_shadow #(
  parameter int unsigned NUM_WORDS = 19,
  parameter int unsigned WORD_W    = 12,
  parameter int unsigned TAG_W     = 10,
  localparam int unsigned IDX_W    = $clog2(NUM_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        wr_en_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [WORD_W-1:0]           wr_data_i,
  input  logic                        commit_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic                        ready_i,
  output logic [NUM_WORDS*WORD_W-1:0] params_o,
  output logic                        valid_o,
  output logic [TAG_W-1:0]            tag_o,
  output logic                        overflow_o
);
  import stage_db_pkg::*;

  localparam int unsigned REC_W = NUM_WORDS * WORD_W;

  logic [REC_W-1:0] shadow_q, shadow_d;
  logic [REC_W-1:0] out_q, out_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             load;

  // Merge the incoming word so a commit captures the record including its last word.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
        shadow_d[slot_lsb(k, WORD_W) +: WORD_W] = wr_data_i;
      end
    end
  end

  // Output register load, valid and overflow next-state.
  always_comb begin
    load    = commit_i && (!valid_q || ready_i);
    out_d   = out_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (load) begin
      out_d   = shadow_d;
      tag_d   = tag_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
    if (clear_i) begin
      ovf_d = 1'b0;
    end else if (commit_i && !load) begin
      ovf_d = 1'b1;
    end
  end

  // State registers; reset discards any partial record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      out_q    <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign params_o   = out_q;
  assign valid_o    = valid_q;
  assign tag_o      = tag_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/stage_param_collector.sv
// Receiving end of the stage-database stream: requests a stage, packs
// incoming words into classifier records, then captures stage thresholds.
// Output handshake: a record transfers on a rising edge where o_params_valid
// and i_params_ready are both high. The input side has no backpressure.
module stage_param_collector #(
  parameter int unsigned ADDR_WIDTH               = 10,
  parameter int unsigned DATA_WIDTH_12            = stage_db_pkg::DATA_WIDTH_12,
  parameter int unsigned NUM_CLASSIFIERS_STAGE    = 10,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int unsigned NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  output logic                                              o_rden,
  input  logic                                              i_data_valid,
  input  logic [DATA_WIDTH_12-1:0]                          i_data_database,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0] o_params,
  output logic                                              o_params_valid,
  input  logic                                              i_params_ready,
  output logic [ADDR_WIDTH-1:0]                             o_tree_index,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_12-1:0]      o_stage_threshold,
  output logic                                              o_stage_done,
  output logic                                              o_busy,
  output logic                                              o_overflow,
  output logic [2:0]                                        o_dbg_state
);
  import stage_db_pkg::*;

  localparam int unsigned WCW   = $clog2(NUM_PARAM_PER_CLASSIFIER);
  localparam int unsigned TCW   = $clog2(NUM_STAGE_THRESHOLD) + 1;
  localparam int unsigned THR_W = NUM_STAGE_THRESHOLD * DATA_WIDTH_12;

  localparam logic [WCW-1:0]        WORD_LAST  = WCW'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [ADDR_WIDTH-1:0] CLASS_LAST = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);
  localparam logic [TCW-1:0]        THR_LAST   = TCW'(NUM_STAGE_THRESHOLD - 1);

  stage_state_e          state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] class_cnt_q, class_cnt_d;
  logic [TCW-1:0]        thr_cnt_q, thr_cnt_d;
  logic [THR_W-1:0]      thr_q, thr_d;
  logic                  done_q, done_d;
  logic                  rden;
  logic                  wr_en;
  logic                  commit;
  logic                  clear;

  // FSM next-state, counters, threshold capture and shadow control strobes.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    class_cnt_d = class_cnt_q;
    thr_cnt_d   = thr_cnt_q;
    thr_d       = thr_q;
    done_d      = done_q;
    rden        = 1'b0;
    wr_en       = 1'b0;
    commit      = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d     = REQ;
          clear       = 1'b1;
          done_d      = 1'b0;
          thr_d       = '0;
          word_cnt_d  = '0;
          class_cnt_d = '0;
          thr_cnt_d   = '0;
        end
      end
      REQ: begin
        rden    = 1'b1;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (i_data_valid) begin
          wr_en = 1'b1;
          if (word_cnt_q == WORD_LAST) begin
            commit     = 1'b1;
            word_cnt_d = '0;
            if (class_cnt_q == CLASS_LAST) begin
              state_d = THRESH;
            end else begin
              class_cnt_d = class_cnt_q + 1'b1;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      THRESH: begin
        if (i_data_valid) begin
          for (int k = 0; k < int'(NUM_STAGE_THRESHOLD); k++) begin
            if (thr_cnt_q == TCW'(k)) begin
              thr_d[slot_lsb(k, DATA_WIDTH_12) +: DATA_WIDTH_12] = i_data_database;
            end
          end
          if (thr_cnt_q == THR_LAST) begin
            state_d = DONE;
          end else begin
            thr_cnt_d = thr_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      class_cnt_q <= '0;
      thr_cnt_q   <= '0;
      thr_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      class_cnt_q <= class_cnt_d;
      thr_cnt_q   <= thr_cnt_d;
      thr_q       <= thr_d;
      done_q      <= done_d;
    end
  end

  stage_param_shadow #(
    .NUM_WORDS(NUM_PARAM_PER_CLASSIFIER),
    .WORD_W   (DATA_WIDTH_12),
    .TAG_W    (ADDR_WIDTH)
  ) u_shadow (
    .clk_i     (clk_fpga),
    .rst_ni    (reset_fpga),
    .clear_i   (clear),
    .wr_en_i   (wr_en),
    .wr_idx_i  (word_cnt_q),
    .wr_data_i (i_data_database),
    .commit_i  (commit),
    .tag_i     (class_cnt_q),
    .ready_i   (i_params_ready),
    .params_o  (o_params),
    .valid_o   (o_params_valid),
    .tag_o     (o_tree_index),
    .overflow_o(o_overflow)
  );

  assign o_rden            = rden;
  assign o_stage_threshold = thr_q;
  assign o_stage_done      = done_q;
  assign o_busy            = (state_q != IDLE);
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_stage_param_collector.sv
// Directed bench for stage_param_collector with N=10, P=19, T=3.
module tb_stage_param_collector;

  localparam int P  = 19;
  localparam int N  = 10;
  localparam int T  = 3;
  localparam int W  = 12;
  localparam int RW = P * W;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga;
  logic          i_start;
  logic          o_rden;
  logic          i_data_valid;
  logic [W-1:0]  i_data_database;
  logic [RW-1:0] o_params;
  logic          o_params_valid;
  logic          i_params_ready;
  logic [9:0]    o_tree_index;
  logic [T*W-1:0] o_stage_threshold;
  logic          o_stage_done;
  logic          o_busy;
  logic          o_overflow;
  logic [2:0]    o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [RW-1:0]  got_q[$];
  logic [9:0]     got_tag[$];
  logic [RW-1:0]  exp_q[$];
  int             rden_cnt = 0;

  localparam logic [T*W-1:0] EXP_THR = {12'd192, 12'd191, 12'd190};

  stage_param_collector dut (
    .clk_fpga         (clk_fpga),
    .reset_fpga       (reset_fpga),
    .i_start          (i_start),
    .o_rden           (o_rden),
    .i_data_valid     (i_data_valid),
    .i_data_database  (i_data_database),
    .o_params         (o_params),
    .o_params_valid   (o_params_valid),
    .i_params_ready   (i_params_ready),
    .o_tree_index     (o_tree_index),
    .o_stage_threshold(o_stage_threshold),
    .o_stage_done     (o_stage_done),
    .o_busy           (o_busy),
    .o_overflow       (o_overflow),
    .o_dbg_state      (o_dbg_state)
  );

  // clock / reset
  always #5 clk_fpga = ~clk_fpga;

  // monitor: records transferred and read requests, sampled mid-cycle
  always @(negedge clk_fpga) begin
    if (reset_fpga && o_params_valid && i_params_ready) begin
      got_q.push_back(o_params);
      got_tag.push_back(o_tree_index);
    end
    if (o_rden) rden_cnt++;
  end

  function automatic logic [RW-1:0] exp_rec(input int n);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) r[k*W +: W] = W'(19 * n + k);
    return r;
  endfunction

  // drivers
  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_reset();
    reset_fpga      = 1'b0;
    i_start         = 1'b0;
    i_data_valid    = 1'b0;
    i_data_database = '0;
    i_params_ready  = 1'b0;
    tick();
    tick();
    reset_fpga = 1'b1;
    tick();
  endtask

  task automatic start_stage();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] v);
    i_data_valid    = 1'b1;
    i_data_database = v;
    tick();
    i_data_valid    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset_fpga = 1'b0;
    #1;
    n_vec++; if (o_rden !== 1'b0) begin n_err++; $display("FAIL reset_rden: got %b expected 0", o_rden); end
    n_vec++; if (o_params !== '0) begin n_err++; $display("FAIL reset_params: got %h expected 0", o_params); end
    n_vec++; if (o_params_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_params_valid); end
    n_vec++; if (o_tree_index !== '0) begin n_err++; $display("FAIL reset_tree_index: got %0d expected 0", o_tree_index); end
    n_vec++; if (o_stage_threshold !== '0) begin n_err++; $display("FAIL reset_threshold: got %h expected 0", o_stage_threshold); end
    n_vec++; if (o_stage_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_stage_done); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
    n_vec++; if (o_dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state); end
    reset_fpga = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int g0, r0;
    do_reset();
    g0 = got_q.size();
    r0 = rden_cnt;
    i_params_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_vec++; if (o_rden !== 1'b1) begin n_err++; $display("FAIL nom_rden_high: got %b expected 1", o_rden); end
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL nom_busy: got %b expected 1", o_busy); end
    tick();
    n_vec++; if (o_rden !== 1'b0) begin n_err++; $display("FAIL nom_rden_low: got %b expected 0", o_rden); end
    for (int w = 0; w < 193; w++) send_word(W'(w));
    n_vec++; if (o_dbg_state !== 3'd4) begin n_err++; $display("FAIL nom_state_done: got %0d expected 4", o_dbg_state); end
    n_vec++; if (o_stage_done !== 1'b0) begin n_err++; $display("FAIL nom_done_early: got %b expected 0", o_stage_done); end
    tick();
    n_vec++; if (o_stage_done !== 1'b1) begin n_err++; $display("FAIL nom_done: got %b expected 1", o_stage_done); end
    n_vec++; if (o_stage_threshold !== EXP_THR) begin n_err++; $display("FAIL nom_threshold: got %h expected %h", o_stage_threshold, EXP_THR); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL nom_overflow: got %b expected 0", o_overflow); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL nom_idle: got %b expected 0", o_busy); end
    n_vec++; if (rden_cnt - r0 !== 1) begin n_err++; $display("FAIL nom_rden_count: got %0d expected 1", rden_cnt - r0); end
    n_vec++; if (got_q.size() - g0 !== N) begin n_err++; $display("FAIL nom_record_count: got %0d expected %0d", got_q.size() - g0, N); end
    for (int n = 0; n < N; n++) exp_q.push_back(exp_rec(n));
    for (int n = 0; n < N; n++) begin
      logic [RW-1:0] e;
      e = exp_q.pop_front();
      if (g0 + n < got_q.size()) begin
        n_vec++; if (got_q[g0+n] !== e) begin n_err++; $display("FAIL nom_record_%0d: got %h expected %h", n, got_q[g0+n], e); end
        n_vec++; if (got_tag[g0+n] !== 10'(n)) begin n_err++; $display("FAIL nom_tree_index_%0d: got %0d expected %0d", n, got_tag[g0+n], n); end
      end
    end
  endtask

  task automatic test_gapped();
    int g0;
    do_reset();
    g0 = got_q.size();
    i_params_ready = 1'b1;
    start_stage();
    for (int w = 0; w < 193; w++) begin
      send_word(W'(w));
      if ((w % 19) == 18 && w < 190) begin
        n_vec++;
        if (o_params_valid !== 1'b1 || o_tree_index !== 10'(w / 19) || o_params[W-1:0] !== W'(w - 18)) begin
          n_err++;
          $display("FAIL gap_latency_%0d: got valid=%b idx=%0d w0=%0d expected valid=1 idx=%0d w0=%0d",
                   w / 19, o_params_valid, o_tree_index, o_params[W-1:0], w / 19, w - 18);
        end
      end
      tick();
    end
    n_vec++; if (o_stage_done !== 1'b1) begin n_err++; $display("FAIL gap_done: got %b expected 1", o_stage_done); end
    n_vec++; if (o_stage_threshold !== EXP_THR) begin n_err++; $display("FAIL gap_threshold: got %h expected %h", o_stage_threshold, EXP_THR); end
    n_vec++; if (got_q.size() - g0 !== N) begin n_err++; $display("FAIL gap_record_count: got %0d expected %0d", got_q.size() - g0, N); end
    for (int n = 0; n < N; n++) exp_q.push_back(exp_rec(n));
    for (int n = 0; n < N; n++) begin
      logic [RW-1:0] e;
      e = exp_q.pop_front();
      if (g0 + n < got_q.size()) begin
        n_vec++; if (got_q[g0+n] !== e) begin n_err++; $display("FAIL gap_record_%0d: got %h expected %h", n, got_q[g0+n], e); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_params_ready = 1'b0;
    start_stage();
    for (int w = 0; w < 38; w++) begin
      send_word(W'(w));
      if (w == 18) begin
        n_vec++; if (o_params_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_rec0: got %b expected 1", o_params_valid); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL bp_no_overflow_yet: got %b expected 0", o_overflow); end
      end
    end
    n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b expected 1", o_overflow); end
    n_vec++; if (o_params !== exp_rec(0)) begin n_err++; $display("FAIL bp_record_held: got %h expected %h", o_params, exp_rec(0)); end
    n_vec++; if (o_tree_index !== 10'd0) begin n_err++; $display("FAIL bp_tree_index: got %0d expected 0", o_tree_index); end
    n_vec++; if (o_params_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b expected 1", o_params_valid); end
  endtask

  task automatic test_simultaneous();
    int g0;
    do_reset();
    i_params_ready = 1'b0;
    start_stage();
    for (int w = 0; w < 37; w++) send_word(W'(w));
    g0 = got_q.size();
    i_params_ready = 1'b1;
    send_word(W'(37));
    i_params_ready = 1'b0;
    n_vec++; if (o_params_valid !== 1'b1) begin n_err++; $display("FAIL sim_valid: got %b expected 1", o_params_valid); end
    n_vec++; if (o_params[W-1:0] !== W'(19)) begin n_err++; $display("FAIL sim_word0: got %0d expected 19", o_params[W-1:0]); end
    n_vec++; if (o_params !== exp_rec(1)) begin n_err++; $display("FAIL sim_record1: got %h expected %h", o_params, exp_rec(1)); end
    n_vec++; if (o_tree_index !== 10'd1) begin n_err++; $display("FAIL sim_tree_index: got %0d expected 1", o_tree_index); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL sim_overflow: got %b expected 0", o_overflow); end
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL sim_accept_count: got %0d expected 1", got_q.size() - g0); end
    else begin
      n_vec++; if (got_q[g0] !== exp_rec(0)) begin n_err++; $display("FAIL sim_accepted_rec0: got %h expected %h", got_q[g0], exp_rec(0)); end
    end
  endtask

  task automatic test_mid_reset();
    int g0;
    do_reset();
    i_params_ready = 1'b1;
    start_stage();
    for (int w = 0; w < 50; w++) send_word(W'(w));
    reset_fpga = 1'b0;
    #1;
    n_vec++; if (o_params_valid !== 1'b0 || o_params !== '0 || o_tree_index !== '0) begin
      n_err++; $display("FAIL mrst_record: got valid=%b params=%h idx=%0d expected all 0", o_params_valid, o_params, o_tree_index); end
    n_vec++; if (o_busy !== 1'b0 || o_dbg_state !== 3'd0 || o_rden !== 1'b0) begin
      n_err++; $display("FAIL mrst_state: got busy=%b state=%0d rden=%b expected 0", o_busy, o_dbg_state, o_rden); end
    n_vec++; if (o_stage_done !== 1'b0 || o_overflow !== 1'b0 || o_stage_threshold !== '0) begin
      n_err++; $display("FAIL mrst_flags: got done=%b ovf=%b thr=%h expected 0", o_stage_done, o_overflow, o_stage_threshold); end
    tick();
    reset_fpga = 1'b1;
    tick();
    g0 = got_q.size();
    start_stage();
    for (int w = 0; w < 193; w++) send_word(W'(w));
    tick();
    n_vec++; if (o_stage_done !== 1'b1) begin n_err++; $display("FAIL mrst_done: got %b expected 1", o_stage_done); end
    n_vec++; if (o_stage_threshold !== EXP_THR) begin n_err++; $display("FAIL mrst_threshold: got %h expected %h", o_stage_threshold, EXP_THR); end
    n_vec++; if (got_q.size() - g0 !== N) begin n_err++; $display("FAIL mrst_record_count: got %0d expected %0d", got_q.size() - g0, N); end
    for (int n = 0; n < N; n++) exp_q.push_back(exp_rec(n));
    for (int n = 0; n < N; n++) begin
      logic [RW-1:0] e;
      e = exp_q.pop_front();
      if (g0 + n < got_q.size()) begin
        n_vec++; if (got_q[g0+n] !== e || got_tag[g0+n] !== 10'(n)) begin
          n_err++; $display("FAIL mrst_record_%0d: got %h idx %0d expected %h idx %0d", n, got_q[g0+n], got_tag[g0+n], e, n); end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int g0, r0;
    do_reset();
    i_params_ready = 1'b1;
    r0 = rden_cnt;
    for (int w = 500; w < 505; w++) send_word(W'(w));
    tick();
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy: got %b expected 0", o_busy); end
    n_vec++; if (o_params_valid !== 1'b0) begin n_err++; $display("FAIL ign_idle_valid: got %b expected 0", o_params_valid); end
    n_vec++; if (rden_cnt !== r0) begin n_err++; $display("FAIL ign_idle_rden: got %0d expected %0d", rden_cnt, r0); end
    g0 = got_q.size();
    start_stage();
    for (int w = 0; w < 193; w++) begin
      if (w == 5) i_start = 1'b1;
      send_word(W'(w));
      i_start = 1'b0;
    end
    tick();
    n_vec++; if (rden_cnt - r0 !== 1) begin n_err++; $display("FAIL ign_rden_count: got %0d expected 1", rden_cnt - r0); end
    n_vec++; if (o_stage_done !== 1'b1) begin n_err++; $display("FAIL ign_done: got %b expected 1", o_stage_done); end
    n_vec++; if (got_q.size() - g0 !== N) begin n_err++; $display("FAIL ign_record_count: got %0d expected %0d", got_q.size() - g0, N); end
    else begin
      n_vec++; if (got_q[g0] !== exp_rec(0)) begin n_err++; $display("FAIL ign_record0: got %h expected %h", got_q[g0], exp_rec(0)); end
      n_vec++; if (got_q[g0+N-1] !== exp_rec(N-1)) begin n_err++; $display("FAIL ign_record9: got %h expected %h", got_q[g0+N-1], exp_rec(N-1)); end
    end
  endtask

  initial begin
    reset_fpga      = 1'b0;
    i_start         = 1'b0;
    i_data_valid    = 1'b0;
    i_data_database = '0;
    i_params_ready  = 1'b0;
    test_reset();
    test_nominal();
    test_gapped();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_param_collector.md
# stage_param_collector

Receiving end of the stage-database stream. On `i_start` it issues the read request to the stage database reader. It then accepts one 12-bit word per valid cycle and packs every `NUM_PARAM_PER_CLASSIFIER` words into one classifier record, presented on a valid/ready output. After `NUM_CLASSIFIERS_STAGE` records it captures `NUM_STAGE_THRESHOLD` stage-threshold words and flags the stage complete for the Haar stage evaluator.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: width of classifier index
- `DATA_WIDTH_12`, 12: database word width
- `NUM_CLASSIFIERS_STAGE`, 10: classifiers per stage (N)
- `NUM_PARAM_PER_CLASSIFIER`, 19: words per classifier (P)
- `NUM_STAGE_THRESHOLD`, 3: trailing threshold words (T)

Ports:
- `clk_fpga`, in, 1: the single clock; all logic on its rising edge
- `reset_fpga`, in, 1: asynchronous, active-low reset
- `i_start`, in, 1: one-cycle pulse that begins a stage load
- `o_rden`, out, 1: one-cycle read-request pulse to the database reader
- `i_data_valid`, in, 1: `i_data_database` holds a word this cycle
- `i_data_database`, in, 12: database word
- `o_params`, out, P*12: classifier record; word k is at bits [12k+11:12k], word 0 is the first received
- `o_params_valid`, out, 1: record available
- `i_params_ready`, in, 1: consumer accepts the record when both valid and ready are high
- `o_tree_index`, out, ADDR_WIDTH: classifier number (0..N-1) of the record on `o_params`
- `o_stage_threshold`, out, T*12: threshold words, same packing as `o_params`
- `o_stage_done`, out, 1: level; all N records and T thresholds received
- `o_busy`, out, 1: FSM not IDLE
- `o_overflow`, out, 1: sticky; a record completed while the output register was still full

## Operation
- FSM states and transitions:
  - IDLE: on `i_start` go to REQ and clear `o_stage_done`, `o_overflow`, thresholds and all counters. `i_start` in any other state is ignored.
  - REQ: drive `o_rden` high for exactly this cycle, then go to COLLECT.
  - COLLECT: each valid word is written into slot `word_cnt` of the shadow record and `word_cnt` increments. When `word_cnt` = P-1, the record is complete: the shadow moves to the output register, `word_cnt` returns to 0 and `class_cnt` increments. If `class_cnt` = N-1, go to THRESH.
  - THRESH: each valid word is written to threshold slot `thr_cnt`. When `thr_cnt` = T-1, go to DONE.
  - DONE: set `o_stage_done` for one transition, then go to IDLE. `o_stage_done` stays high until the next `i_start`.
- Output register load rule: a completed record loads when `o_params_valid` = 0, or when the current record is being accepted in that same cycle. Otherwise the new record is dropped, the old record stays unchanged and `o_overflow` is set.
- `o_params_valid` clears after a handshake unless a new record loads on the same edge.
- `o_tree_index` loads together with `o_params`.
- Valid words arriving in IDLE, REQ or DONE are discarded.
- Reset: all outputs 0, FSM in IDLE, counters 0. An asynchronous reset mid-load aborts the load and no partial record is ever presented.
- Counter widths: `word_cnt` is clog2(P); `class_cnt` is ADDR_WIDTH; `thr_cnt` is clog2(T)+1. None of them may wrap past their terminal value.

## Timing
- `o_rden` is high in the cycle after `i_start` is sampled.
- Last word of a record sampled at edge k: `o_params_valid` = 1 and the record is visible after edge k (1-cycle latency).
- Last threshold word sampled at edge k: FSM is in DONE after k; `o_stage_done` = 1 after k+1.
- Back-to-back words are accepted at full rate, one per clock, with no stall toward the reader. There is no backpressure upstream; that is why overflow is detected rather than prevented.
- A handshake and a new record load on the same edge: the new record wins, and `o_params_valid` stays 1.

## Structure
- Shared package `stage_db_pkg` holds:
  - `DATA_WIDTH_12`
  - `DEFAULT_VALUE` = 1010
  - the FSM state typedef: IDLE, REQ, COLLECT, THRESH, DONE
  - a packing function for word slot offsets
- Sub-module `stage_param_shadow`: P-slot word register with indexed write and a parallel-load output register, including the valid/ready/overflow logic. The FSM and counters remain in the top module.

## Test plan
- Nominal load: with N=10, P=19, T=3, `i_start` then 193 consecutive words of value 0..192 with `i_params_ready` = 1 → one `o_rden` pulse; 10 records, record n word k = 19n+k and `o_tree_index` = n; thresholds = 190, 191, 192; `o_stage_done` = 1; `o_overflow` = 0.
- Gapped input: `i_data_valid` toggling 1,0,1,0 over the same 193 words → identical records, each delivered 1 cycle after its last valid word.
- Backpressure: `i_params_ready` = 0 throughout → record 0 is held; record 1 is dropped and `o_overflow` = 1; `o_params` stays record 0 (word 0 = 0).
- Simultaneous accept and load: ready asserted on exactly the edge record 1 completes → `o_params_valid` stays 1, `o_params` word 0 = 19, no overflow.
- Mid-load reset: `reset_fpga` driven low after 50 words → all outputs 0 and state IDLE. A new `i_start` plus 193 words then gives the nominal result.
- Ignored inputs: `i_start` pulsed during COLLECT, and 5 valid words sent while in IDLE → no second `o_rden`, and record 0 word 0 equals the first word received after REQ.
